rou_axi_req: RTL and testbench
==============================

ROU_AXI_REQ -- requirements
Module: rou_axi_req

Interface
REQ-001 Parameters (name, default, meaning): DWID 128 data width; AWID 32 address width; TWID 5 tag width; BWID 4 log2(DWID/8), derived; WID 2+DWID+AWID+BWID+TWID message width.
REQ-002 Message layout, MSB to LSB, SHALL be: cmd[2], data[DWID], addr[AWID], bfield[BWID], tag[TWID]. Request cmd: 01 write, 10 read, 00/11 illegal.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_msg  in  WID  request from ring interface; req_valid  in  1  request present.
REQ-006 req_ack  out  1  one-cycle pulse when request is taken.
REQ-007 rsp_msg  out  WID  response to ring interface; rsp_valid  out  1  response present.
REQ-008 rsp_ack  in  1  response consumed.
REQ-009 AXI AW  out: awid[4], awaddr[AWID], awlen[8], awsize[3], awburst[2], awvalid; in: awready.
REQ-010 AXI W  out: wdata[DWID], wstrb[DWID/8], wlast, wvalid; in: wready.
REQ-011 AXI B  in: bid[4], bresp[2], bvalid; out: bready.
REQ-012 AXI AR  out: arid[4], araddr[AWID], arlen[8], arsize[3], arburst[2], arvalid; in: arready.
REQ-013 AXI R  in: rid[4], rdata[DWID], rresp[2], rlast, rvalid; out: rready.

Function
REQ-014 One outstanding transaction; single-beat only: awlen=arlen=0, awsize=arsize=BWID, awburst=arburst=01, wstrb all ones, wlast=1, awid=arid=tag[3:0].
REQ-015 States: IDLE, WADDR, WRESP, RADDR, RDATA, RSP.
REQ-016 IDLE: req_valid with cmd 01 -> latch message, req_ack=1, go WADDR; cmd 10 -> latch, req_ack, go RADDR; cmd 00/11 -> req_ack, drop, stay IDLE.
REQ-017 WADDR: awvalid and wvalid asserted together next cycle after accept; each deasserts independently after its own ready handshake; go WRESP when both done (same-cycle or either order).
REQ-018 WRESP: bready=1; on bvalid latch bresp, go RSP.
REQ-019 RADDR: arvalid=1 until arready, then RDATA; RDATA: rready=1, on rvalid latch rdata and rresp, go RSP.
REQ-020 RSP: rsp_valid=1, rsp_msg held stable until rsp_ack; on rsp_ack go IDLE; next request accepted no earlier than cycle after rsp_ack.
REQ-021 Response cmd = 01 if resp==00 or 01, else 11; data = rdata for read, zero for write; addr, bfield, tag echoed from request.
REQ-022 AXI valids SHALL NOT drop before ready; AXI payloads stable while valid.
REQ-023 Mismatched bid/rid vs tag[3:0] SHALL be treated as normal response (single outstanding).
REQ-024 req_ack only in IDLE; latency req_valid to awvalid/arvalid = 1 cycle.

Reset
REQ-025 On rst_n low, immediately: state IDLE; req_ack, rsp_valid, awvalid, wvalid, arvalid, bready, rready = 0; rsp_msg and latched fields = 0.
REQ-026 Reset mid-transaction abandons it; no response generated; AXI valids drop asynchronously.

Configuration
REQ-027 Macro ROU_AXI_TIMEOUT_EN defined: 10-bit counter cleared on entry to WRESP/RDATA; at 1023 cycles without bvalid/rvalid go RSP with cmd 11, data 0; in IDLE bready=rready=1 to drain and discard late responses.
REQ-028 Macro undefined: no counter, WRESP/RDATA wait indefinitely, bready=rready=0 in IDLE.

Verification
REQ-029 Write cmd 01, addr 0x1000, tag 5, awready/wready immediate, bresp 00 -> awaddr 0x1000, awid 5, one AW and one W handshake, rsp cmd 01 data 0 tag 5.
REQ-030 Read cmd 10, addr 0x2000, rdata 0xA5..A5, rresp 00 -> arlen 0, rsp cmd 01 data 0xA5..A5 addr 0x2000.
REQ-031 Write with wready 3 cycles after awready, then bresp 10 -> wvalid held 3 cycles, rsp cmd 11.
REQ-032 rsp_ack held low 10 cycles with req_valid high -> rsp_msg stable, no req_ack until cycle after rsp_ack.
REQ-033 With ROU_AXI_TIMEOUT_EN, read with rvalid never -> rsp cmd 11 after 1023 cycles; late rvalid in IDLE consumed, no response.
REQ-034 rst_n low during WADDR -> awvalid/wvalid 0 immediately, state IDLE, no rsp_valid.

Source files
------------

// File: rtl/rou_axi_req.sv
// Ring-to-AXI request bridge: one outstanding single-beat AXI read or write per ring request.
// Optional macro ROU_AXI_TIMEOUT_EN adds a response timeout and drains late B/R beats while idle.
module rou_axi_req #(
   parameter int DWID = 128,
   parameter int AWID = 32,
   parameter int TWID = 5,
   parameter int BWID = $clog2(DWID/8),
   parameter int WID  = 2+DWID+AWID+BWID+TWID
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WID-1:0]    req_msg,
   input  logic              req_valid,
   output logic              req_ack,
   output logic [WID-1:0]    rsp_msg,
   output logic              rsp_valid,
   input  logic              rsp_ack,
   output logic [3:0]        awid,
   output logic [AWID-1:0]   awaddr,
   output logic [7:0]        awlen,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   output logic              awvalid,
   input  logic              awready,
   output logic [DWID-1:0]   wdata,
   output logic [DWID/8-1:0] wstrb,
   output logic              wlast,
   output logic              wvalid,
   input  logic              wready,
   input  logic [3:0]        bid,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready,
   output logic [3:0]        arid,
   output logic [AWID-1:0]   araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic              arvalid,
   input  logic              arready,
   input  logic [3:0]        rid,
   input  logic [DWID-1:0]   rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready
);

   // state  | meaning
   // IDLE   | waiting for a ring request; illegal commands are acked and dropped
   // WADDR  | AW and W presented together, each retired by its own handshake
   // WRESP  | waiting for the B beat
   // RADDR  | AR presented until arready
   // RDATA  | waiting for the R beat
   // RSP    | response held on the ring until rsp_ack
   typedef enum logic [2:0] {
      S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_RSP
   } state_t;

   localparam logic [1:0] CMD_WR  = 2'b01;
   localparam logic [1:0] CMD_RD  = 2'b10;
   localparam logic [1:0] CMD_ERR = 2'b11;

   state_t            state_q, state_nxt;
   logic [1:0]        req_cmd;
   logic              acc_wr, acc_rd;
   logic [DWID-1:0]   data_q;
   logic [AWID-1:0]   addr_q;
   logic [BWID-1:0]   bf_q;
   logic [TWID-1:0]   tag_q;
   logic              aw_pend_q, w_pend_q;
   logic              aw_done, w_done;
   logic [WID-1:0]    rsp_q;
   logic              tmo;
   logic              drain_idle;
   logic              unused_ok;

   assign req_cmd   = req_msg[WID-1 -: 2];
   assign acc_wr    = (state_q == S_IDLE) && req_valid && (req_cmd == CMD_WR);
   assign acc_rd    = (state_q == S_IDLE) && req_valid && (req_cmd == CMD_RD);
   assign aw_done   = !aw_pend_q || awready;
   assign w_done    = !w_pend_q || wready;
   assign unused_ok = ^{bid, rid, rlast};

   function automatic logic [1:0] resp_cmd(input logic [1:0] resp);
      return resp[1] ? CMD_ERR : CMD_WR;
   endfunction

`ifdef ROU_AXI_TIMEOUT_EN
   logic [9:0] tmo_cnt_q;

   // cycles left before giving up on B/R; reloaded whenever not waiting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tmo_cnt_q <= '0;
      else if (state_q != S_WRESP && state_q != S_RDATA)
         tmo_cnt_q <= 10'd1022;
      else if (tmo_cnt_q != 10'd0)
         tmo_cnt_q <= tmo_cnt_q - 10'd1;
   end

   assign tmo        = (state_q == S_WRESP || state_q == S_RDATA) && (tmo_cnt_q == 10'd0);
   assign drain_idle = 1'b1;
`else
   assign tmo        = 1'b0;
   assign drain_idle = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE:  if (acc_wr) state_nxt = S_WADDR;
                  else if (acc_rd) state_nxt = S_RADDR;
         S_WADDR: if (aw_done && w_done) state_nxt = S_WRESP;
         S_WRESP: if (bvalid || tmo) state_nxt = S_RSP;
         S_RADDR: if (arready) state_nxt = S_RDATA;
         S_RDATA: if (rvalid || tmo) state_nxt = S_RSP;
         S_RSP:   if (rsp_ack) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // rst_n gating keeps the handshake outputs low for the whole reset window
   always_comb begin
      req_ack   = rst_n && (state_q == S_IDLE) && req_valid;
      awvalid   = aw_pend_q;
      wvalid    = w_pend_q;
      arvalid   = (state_q == S_RADDR);
      bready    = (state_q == S_WRESP) || (rst_n && drain_idle && state_q == S_IDLE);
      rready    = (state_q == S_RDATA) || (rst_n && drain_idle && state_q == S_IDLE);
      rsp_valid = (state_q == S_RSP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q    <= '0;
         addr_q    <= '0;
         bf_q      <= '0;
         tag_q     <= '0;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         rsp_q     <= '0;
      end else begin
         if (acc_wr || acc_rd) begin
            data_q <= req_msg[AWID+BWID+TWID +: DWID];
            addr_q <= req_msg[BWID+TWID +: AWID];
            bf_q   <= req_msg[TWID +: BWID];
            tag_q  <= req_msg[TWID-1:0];
         end
         if (acc_wr) begin
            aw_pend_q <= 1'b1;
            w_pend_q  <= 1'b1;
         end else begin
            if (aw_pend_q && awready) aw_pend_q <= 1'b0;
            if (w_pend_q && wready)   w_pend_q  <= 1'b0;
         end
         if (state_q == S_WRESP && (bvalid || tmo))
            rsp_q <= {bvalid ? resp_cmd(bresp) : CMD_ERR, {DWID{1'b0}}, addr_q, bf_q, tag_q};
         else if (state_q == S_RDATA && (rvalid || tmo))
            rsp_q <= {rvalid ? resp_cmd(rresp) : CMD_ERR, rvalid ? rdata : {DWID{1'b0}},
                      addr_q, bf_q, tag_q};
      end
   end

   assign rsp_msg = rsp_q;
   assign awid    = tag_q[3:0];
   assign awaddr  = addr_q;
   assign awlen   = 8'd0;
   assign awsize  = 3'(BWID);
   assign awburst = 2'b01;
   assign wdata   = data_q;
   assign wstrb   = '1;
   assign wlast   = 1'b1;
   assign arid    = tag_q[3:0];
   assign araddr  = addr_q;
   assign arlen   = 8'd0;
   assign arsize  = 3'(BWID);
   assign arburst = 2'b01;

endmodule

// File: tb/tb_rou_axi_req.sv
// Randomized bench for rou_axi_req: a transaction-level AXI slave/ring model predicts every response.
module tb_rou_axi_req;
   localparam int DWID = 128;
   localparam int AWID = 32;
   localparam int TWID = 5;
   localparam int BWID = 4;
   localparam int WID  = 2+DWID+AWID+BWID+TWID;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [WID-1:0]    req_msg;
   logic              req_valid;
   logic              req_ack;
   logic [WID-1:0]    rsp_msg;
   logic              rsp_valid;
   logic              rsp_ack;
   logic [3:0]        awid;
   logic [AWID-1:0]   awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awvalid;
   logic              awready;
   logic [DWID-1:0]   wdata;
   logic [DWID/8-1:0] wstrb;
   logic              wlast;
   logic              wvalid;
   logic              wready;
   logic [3:0]        bid;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [3:0]        arid;
   logic [AWID-1:0]   araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arvalid;
   logic              arready;
   logic [3:0]        rid;
   logic [DWID-1:0]   rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   int n_chk = 0;
   int n_err = 0;

   rou_axi_req dut (
      .clk(clk), .rst_n(rst_n),
      .req_msg(req_msg), .req_valid(req_valid), .req_ack(req_ack),
      .rsp_msg(rsp_msg), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WID-1:0] obs, input logic [WID-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DWID-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [WID-1:0] mk_msg(input logic [1:0] cmd, input logic [DWID-1:0] data,
                                              input logic [AWID-1:0] addr, input logic [BWID-1:0] bf,
                                              input logic [TWID-1:0] tag);
      return {cmd, data, addr, bf, tag};
   endfunction

   // expected ring response: OKAY/EXOKAY -> 01, anything else or a timeout -> 11
   function automatic logic [WID-1:0] exp_rsp(input bit is_rd, input logic [1:0] resp,
                                               input logic [DWID-1:0] rd, input logic [AWID-1:0] addr,
                                               input logic [BWID-1:0] bf, input logic [TWID-1:0] tag,
                                               input bit timed_out);
      logic [1:0]      cmd;
      logic [DWID-1:0] data;
      cmd  = (timed_out || resp == 2'b10 || resp == 2'b11) ? 2'b11 : 2'b01;
      data = (is_rd && !timed_out) ? rd : '0;
      return mk_msg(cmd, data, addr, bf, tag);
   endfunction

   task automatic idle_inputs();
      req_valid = 1'b0; req_msg = '0; rsp_ack = 1'b0;
      awready = 1'b0; wready = 1'b0;
      bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
      arready = 1'b0;
      rvalid = 1'b0; rdata = '0; rresp = 2'b00; rid = 4'd0; rlast = 1'b0;
   endtask

   task automatic run_txn(input logic [1:0] cmd, input logic [AWID-1:0] addr,
                          input logic [DWID-1:0] data, input logic [TWID-1:0] tag,
                          input logic [BWID-1:0] bf, input int aw_dly, input int w_dly,
                          input int b_dly, input int ar_dly, input int r_dly, input int ack_dly,
                          input logic [1:0] resp, input logic [DWID-1:0] rd);
      logic [WID-1:0] exp;
      int  aw_hs, w_hs;
      bit  aw_done, w_done;
      aw_hs = 0; w_hs = 0; aw_done = 0; w_done = 0;
      req_msg = mk_msg(cmd, data, addr, bf, tag);
      req_valid = 1'b1;
      #1;
      chk("req_ack", req_ack, 1'b1);
      tick();
      req_valid = 1'b0;
      req_msg = mk_msg(2'b01, rnd_data(), $urandom, 4'($urandom), 5'($urandom));
      #1;
      chk("ack_pulse", req_ack, 1'b0);
      if (cmd == 2'b00 || cmd == 2'b11) begin
         chk("drop_awvalid", awvalid, 1'b0);
         chk("drop_arvalid", arvalid, 1'b0);
         chk("drop_rsp", rsp_valid, 1'b0);
         return;
      end
      if (cmd == 2'b01) begin
         for (int c = 0; c <= ((aw_dly > w_dly) ? aw_dly : w_dly); c++) begin
            awready = (c >= aw_dly);
            wready  = (c >= w_dly);
            #1;
            chk("awvalid", awvalid, !aw_done);
            chk("wvalid", wvalid, !w_done);
            chk("arvalid_wr", arvalid, 1'b0);
            if (awvalid) begin
               chk("awaddr", awaddr, addr);
               chk("awid", awid, tag[3:0]);
               chk("awlen", awlen, 8'd0);
               chk("awsize", awsize, 3'd4);
               chk("awburst", awburst, 2'b01);
            end
            if (wvalid) begin
               chk("wdata", wdata, data);
               chk("wstrb", wstrb, {(DWID/8){1'b1}});
               chk("wlast", wlast, 1'b1);
            end
            if (awvalid && awready) aw_hs++;
            if (wvalid && wready)   w_hs++;
            if (awready) aw_done = 1;
            if (wready)  w_done = 1;
            tick();
         end
         awready = 1'b0; wready = 1'b0;
         chk("aw_handshakes", aw_hs, 1);
         chk("w_handshakes", w_hs, 1);
         for (int c = 0; c <= b_dly; c++) begin
            bvalid = (c == b_dly);
            bresp  = resp;
            bid    = 4'($urandom);
            #1;
            chk("bready", bready, 1'b1);
            chk("rsp_early_wr", rsp_valid, 1'b0);
            chk("awvalid_wresp", awvalid, 1'b0);
            tick();
         end
         bvalid = 1'b0;
      end else begin
         for (int c = 0; c <= ar_dly; c++) begin
            arready = (c >= ar_dly);
            #1;
            chk("arvalid", arvalid, 1'b1);
            chk("araddr", araddr, addr);
            chk("arid", arid, tag[3:0]);
            chk("arlen", arlen, 8'd0);
            chk("arsize", arsize, 3'd4);
            chk("arburst", arburst, 2'b01);
            chk("awvalid_rd", awvalid, 1'b0);
            tick();
         end
         arready = 1'b0;
         for (int c = 0; c <= r_dly; c++) begin
            rvalid = (c == r_dly);
            rdata  = (c == r_dly) ? rd : rnd_data();
            rresp  = resp;
            rid    = 4'($urandom);
            rlast  = 1'b1;
            #1;
            chk("rready", rready, 1'b1);
            chk("arvalid_rdata", arvalid, 1'b0);
            chk("rsp_early_rd", rsp_valid, 1'b0);
            tick();
         end
         rvalid = 1'b0;
         rdata = rnd_data();
      end
      exp = exp_rsp(cmd == 2'b10, resp, rd, addr, bf, tag, 1'b0);
      if (ack_dly > 0) begin
         req_valid = 1'b1;
         req_msg = mk_msg(2'b00, rnd_data(), $urandom, 4'($urandom), 5'($urandom));
      end
      for (int c = 0; c < ack_dly; c++) begin
         #1;
         chk("rsp_valid_hold", rsp_valid, 1'b1);
         chk("rsp_msg_hold", rsp_msg, exp);
         chk("req_ack_in_rsp", req_ack, 1'b0);
         tick();
      end
      rsp_ack = 1'b1;
      #1;
      chk("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_msg", rsp_msg, exp);
      chk("req_ack_at_rsp_ack", req_ack, 1'b0);
      tick();
      rsp_ack = 1'b0;
      #1;
      chk("rsp_valid_after_ack", rsp_valid, 1'b0);
      if (ack_dly > 0) begin
         chk("req_ack_after_rsp", req_ack, 1'b1);
         tick();
         req_valid = 1'b0;
         #1;
         chk("held_illegal_dropped", awvalid | arvalid | rsp_valid, 1'b0);
      end
   endtask

   initial begin
      logic [DWID-1:0] a5;
      logic [WID-1:0]  exp;
      int              n, cnt_rsp, cnt_nordy;
      bit              seen;

      idle_inputs();
      rst_n = 1'b0;
      req_valid = 1'b1;
      req_msg = mk_msg(2'b01, rnd_data(), 32'h1234, 4'h3, 5'h7);
      #3;
      chk("rst_req_ack", req_ack, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_msg", rsp_msg, '0);
      chk("rst_awvalid", awvalid, 1'b0);
      chk("rst_wvalid", wvalid, 1'b0);
      chk("rst_arvalid", arvalid, 1'b0);
      chk("rst_bready", bready, 1'b0);
      chk("rst_rready", rready, 1'b0);
      tick(); tick();
      req_valid = 1'b0;
      rst_n = 1'b1;
      tick();

      // single write, immediate ready, OKAY
      run_txn(2'b01, 32'h1000, rnd_data(), 5'd5, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, '0);
      // single read of an A5 pattern
      a5 = {16{8'hA5}};
      run_txn(2'b10, 32'h2000, rnd_data(), 5'd9, 4'h2, 0, 0, 0, 0, 1, 0, 2'b00, a5);
      // W accepted three cycles after AW, SLVERR
      run_txn(2'b01, 32'h3000, rnd_data(), 5'd12, 4'h1, 0, 3, 2, 0, 0, 0, 2'b10, '0);
      // W before AW
      run_txn(2'b01, 32'h3100, rnd_data(), 5'd17, 4'h4, 2, 0, 0, 0, 0, 1, 2'b01, '0);
      // response held 10 cycles with a request waiting
      run_txn(2'b10, 32'h4000, rnd_data(), 5'd30, 4'hf, 0, 0, 0, 2, 0, 10, 2'b11, rnd_data());
      // illegal commands
      run_txn(2'b00, 32'h5000, rnd_data(), 5'd1, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, '0);
      run_txn(2'b11, 32'h5004, rnd_data(), 5'd2, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, '0);

      // reset in the middle of WADDR
      req_msg = mk_msg(2'b01, rnd_data(), 32'h6000, 4'h0, 5'd3);
      req_valid = 1'b1;
      #1;
      tick();
      req_valid = 1'b0;
      #1;
      chk("pre_rst_awvalid", awvalid, 1'b1);
      #2;
      rst_n = 1'b0;
      req_valid = 1'b1;
      #1;
      chk("midrst_awvalid", awvalid, 1'b0);
      chk("midrst_wvalid", wvalid, 1'b0);
      chk("midrst_rsp_valid", rsp_valid, 1'b0);
      chk("midrst_req_ack", req_ack, 1'b0);
      tick(); tick();
      req_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("postrst_awvalid", awvalid | wvalid, 1'b0);
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (rsp_valid || awvalid || arvalid) seen = 1;
      end
      chk("postrst_quiet", seen, 1'b0);

`ifdef ROU_AXI_TIMEOUT_EN
      req_msg = mk_msg(2'b10, rnd_data(), 32'h7000, 4'h6, 5'd21);
      req_valid = 1'b1;
      #1;
      tick();
      req_valid = 1'b0;
      arready = 1'b1;
      #1;
      tick();
      arready = 1'b0;
      n = 0;
      seen = 0;
      for (int c = 0; c < 2000; c++) begin
         #1;
         if (rsp_valid) begin
            seen = 1;
            break;
         end
         if (rready) n++;
         tick();
      end
      chk("tmo_reached", seen, 1'b1);
      chk("tmo_cycles", n, 1023);
      exp = exp_rsp(1'b1, 2'b00, '0, 32'h7000, 4'h6, 5'd21, 1'b1);
      chk("tmo_rsp_msg", rsp_msg, exp);
      rsp_ack = 1'b1;
      tick();
      rsp_ack = 1'b0;
      rvalid = 1'b1;
      rdata = rnd_data();
      #1;
      chk("drain_rready", rready, 1'b1);
      chk("drain_bready", bready, 1'b1);
      tick();
      rvalid = 1'b0;
      #1;
      chk("drain_no_rsp", rsp_valid | arvalid | awvalid, 1'b0);
      tick();
      chk("drain_no_rsp2", rsp_valid, 1'b0);
`else
      #1;
      chk("idle_bready", bready, 1'b0);
      chk("idle_rready", rready, 1'b0);
      req_msg = mk_msg(2'b10, rnd_data(), 32'h7000, 4'h6, 5'd21);
      req_valid = 1'b1;
      #1;
      tick();
      req_valid = 1'b0;
      arready = 1'b1;
      #1;
      tick();
      arready = 1'b0;
      cnt_rsp = 0;
      cnt_nordy = 0;
      for (int c = 0; c < 1100; c++) begin
         #1;
         if (rsp_valid) cnt_rsp++;
         if (!rready)   cnt_nordy++;
         tick();
      end
      chk("no_tmo_rsp", cnt_rsp, 0);
      chk("no_tmo_rready", cnt_nordy, 0);
      a5 = rnd_data();
      rvalid = 1'b1; rdata = a5; rresp = 2'b01;
      tick();
      rvalid = 1'b0;
      #1;
      exp = exp_rsp(1'b1, 2'b01, a5, 32'h7000, 4'h6, 5'd21, 1'b0);
      chk("late_rsp_valid", rsp_valid, 1'b1);
      chk("late_rsp_msg", rsp_msg, exp);
      rsp_ack = 1'b1;
      tick();
      rsp_ack = 1'b0;
`endif

      // random traffic
      for (int t = 0; t < 60; t++) begin
         logic [1:0] cmd;
         int sel;
         sel = int'($urandom_range(0, 15));
         cmd = (sel < 7) ? 2'b01 : (sel < 14) ? 2'b10 : (sel == 14) ? 2'b00 : 2'b11;
         run_txn(cmd, $urandom, rnd_data(), 5'($urandom), 4'($urandom),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                 2'($urandom), rnd_data());
         if ($urandom_range(0, 3) == 0) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
